// File: rtl/fuq_pkg.sv
// Shared types and helpers for the functional-unit issue queue.
// Entry field widths are fixed here; the top-level width parameters
// default to these values and must stay equal to them.
package fuq_pkg;

    localparam int FUQ_INST_ID_BITS   = 6;
    localparam int FUQ_PRN_BITS       = 6;
    localparam int FUQ_MAX_OPERANDS   = 3;
    // Wake buses are zero-padded to this width so one helper serves any
    // WAKE_PORTS up to this limit.
    localparam int FUQ_MAX_WAKE_PORTS = 16;

    typedef struct packed {
        logic                                               valid;
        logic [FUQ_INST_ID_BITS-1:0]                        inst_id;
        logic [31:0]                                        raw_instr;
        logic [63:0]                                        pc;
        logic [FUQ_MAX_OPERANDS-1:0]                        src_valid;
        logic [FUQ_MAX_OPERANDS-1:0]                        src_ready;
        logic [FUQ_MAX_OPERANDS-1:0][FUQ_PRN_BITS-1:0]      src_prn;
        logic [FUQ_MAX_OPERANDS-1:0]                        dst_valid;
        logic [FUQ_MAX_OPERANDS-1:0][FUQ_PRN_BITS-1:0]      dst_prn;
    } iq_entry_t;

    // True when any asserted wake channel broadcasts this PRN.
    function automatic logic prn_match(
        input logic [FUQ_PRN_BITS-1:0]                          prn,
        input logic [FUQ_MAX_WAKE_PORTS-1:0]                    wake_valid,
        input logic [FUQ_MAX_WAKE_PORTS-1:0][FUQ_PRN_BITS-1:0]  wake_prn
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < FUQ_MAX_WAKE_PORTS; w++)
            hit = hit | (wake_valid[w] && (wake_prn[w] == prn));
        return hit;
    endfunction

endpackage

// File: rtl/fu_issue_queue_age_matrix_select.sv
// Age matrix picking the oldest eligible entry and the oldest valid entry.
// older[i][j] = 1 means entry i was allocated before entry j.
module age_matrix_select #(
    parameter int QUEUE_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [QUEUE_SIZE-1:0] valid,
    input  logic [QUEUE_SIZE-1:0] alloc,
    input  logic [QUEUE_SIZE-1:0] free,
    input  logic [QUEUE_SIZE-1:0] eligible,
    output logic [QUEUE_SIZE-1:0] sel_oh,
    output logic [QUEUE_SIZE-1:0] oldest_oh
);

    logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0] older;

    // New entry becomes younger than everyone; a freed/reused row forgets its history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            older <= '0;
        end else if (flush) begin
            older <= '0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++)
                for (int j = 0; j < QUEUE_SIZE; j++)
                    if (alloc[j] && (i != j))
                        older[i][j] <= 1'b1;
                    else if (alloc[i] || free[i])
                        older[i][j] <= 1'b0;
        end
    end

    // An entry wins when no other candidate in the same set is older than it.
    always_comb begin
        sel_oh    = '0;
        oldest_oh = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            logic elig_older, valid_older;
            elig_older  = 1'b0;
            valid_older = 1'b0;
            for (int j = 0; j < QUEUE_SIZE; j++) begin
                elig_older  = elig_older  | (eligible[j] && older[j][i]);
                valid_older = valid_older | (valid[j]    && older[j][i]);
            end
            sel_oh[i]    = eligible[i] && !elig_older;
            oldest_oh[i] = valid[i]    && !valid_older;
        end
    end

endmodule

// File: rtl/fu_issue_queue.sv
// Issue queue for one functional unit: tracks operand readiness from wake
// broadcasts, selects the oldest ready entry, reads the PRF and holds the
// result in a registered valid/ready issue port.
module fu_issue_queue
    import fuq_pkg::*;
#(
    parameter int INST_ID_BITS = FUQ_INST_ID_BITS,
    parameter int PRN_BITS     = FUQ_PRN_BITS,
    parameter int MAX_OPERANDS = FUQ_MAX_OPERANDS,
    parameter int QUEUE_SIZE   = 8,
    parameter int WAKE_PORTS   = 8,
    parameter int IN_ORDER     = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic                                     enq_valid,
    output logic                                     enq_ready,
    input  logic [INST_ID_BITS-1:0]                  enq_inst_id,
    input  logic [31:0]                              enq_raw_instr,
    input  logic [63:0]                              enq_pc,
    input  logic [MAX_OPERANDS-1:0]                  enq_src_valid,
    input  logic [MAX_OPERANDS-1:0]                  enq_src_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    enq_src_prn,
    input  logic [MAX_OPERANDS-1:0]                  enq_dst_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    enq_dst_prn,
    input  logic [WAKE_PORTS-1:0]                    wake_valid,
    input  logic [WAKE_PORTS-1:0][PRN_BITS-1:0]      wake_prn,
    output logic [MAX_OPERANDS-1:0]                  prf_read_enable,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    prf_read_prn,
    input  logic [MAX_OPERANDS-1:0][63:0]            prf_op,
    output logic                                     issue_valid,
    input  logic                                     issue_ready,
    output logic [INST_ID_BITS-1:0]                  issue_inst_id,
    output logic [31:0]                              issue_raw_instr,
    output logic [63:0]                              issue_pc,
    output logic [MAX_OPERANDS-1:0][63:0]            issue_operands,
    output logic [MAX_OPERANDS-1:0]                  issue_dst_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    issue_dst_prn,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]          occupancy
);

    localparam int CNT_W = $clog2(QUEUE_SIZE+1);

    iq_entry_t                                         q [QUEUE_SIZE];
    iq_entry_t                                         enq_e, sel_e;
    logic [CNT_W-1:0]                                  count;
    logic [QUEUE_SIZE-1:0]                             valid_vec, elig_raw, elig;
    logic [QUEUE_SIZE-1:0]                             free_lowest, alloc_oh, free_oh;
    logic [QUEUE_SIZE-1:0]                             sel_oh, oldest_oh;
    logic                                              enq_fire, sel_fire;
    logic [FUQ_MAX_WAKE_PORTS-1:0]                     wv_pad;
    logic [FUQ_MAX_WAKE_PORTS-1:0][FUQ_PRN_BITS-1:0]   wp_pad;

    // Widen the wake buses to the helper's fixed width; unused channels stay idle.
    always_comb begin
        wv_pad = '0;
        wp_pad = '0;
        wv_pad[WAKE_PORTS-1:0] = wake_valid;
        wp_pad[WAKE_PORTS-1:0] = wake_prn;
    end

    // Full is judged on the registered count only, so a same-cycle select
    // never opens a slot for the router.
    assign enq_ready = (count < CNT_W'(QUEUE_SIZE));
    assign enq_fire  = enq_valid && enq_ready;
    assign occupancy = count;

    // Build the incoming entry; a same-cycle wake counts so no wakeup is lost.
    always_comb begin
        enq_e           = '0;
        enq_e.valid     = 1'b1;
        enq_e.inst_id   = enq_inst_id;
        enq_e.raw_instr = enq_raw_instr;
        enq_e.pc        = enq_pc;
        enq_e.src_valid = enq_src_valid;
        enq_e.src_prn   = enq_src_prn;
        enq_e.dst_valid = enq_dst_valid;
        enq_e.dst_prn   = enq_dst_prn;
        for (int s = 0; s < MAX_OPERANDS; s++)
            enq_e.src_ready[s] = !enq_src_valid[s] || enq_src_ready[s] ||
                                 prn_match(enq_src_prn[s], wv_pad, wp_pad);
    end

    // Lowest-index free slot; scanning downward leaves the lowest hit.
    always_comb begin
        free_lowest = '0;
        for (int i = QUEUE_SIZE-1; i >= 0; i--)
            if (!q[i].valid) begin
                free_lowest    = '0;
                free_lowest[i] = 1'b1;
            end
    end

    assign alloc_oh = enq_fire ? free_lowest : '0;

    // Per-entry valid and all-operands-ready flags.
    always_comb begin
        valid_vec = '0;
        elig_raw  = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            valid_vec[i] = q[i].valid;
            elig_raw[i]  = q[i].valid && (&q[i].src_ready);
        end
    end

    generate
        if (IN_ORDER != 0) begin : g_in_order
            assign elig = elig_raw & oldest_oh;
        end else begin : g_ooo
            assign elig = elig_raw;
        end
    endgenerate

    age_matrix_select #(.QUEUE_SIZE(QUEUE_SIZE)) u_age (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .valid     (valid_vec),
        .alloc     (alloc_oh),
        .free      (free_oh),
        .eligible  (elig),
        .sel_oh    (sel_oh),
        .oldest_oh (oldest_oh)
    );

    assign sel_fire = (|sel_oh) && (!issue_valid || issue_ready) && !flush;
    assign free_oh  = sel_fire ? sel_oh : '0;

    // One-hot mux of the selected entry.
    always_comb begin
        sel_e = '0;
        for (int i = 0; i < QUEUE_SIZE; i++)
            if (sel_oh[i])
                sel_e = q[i];
    end

    assign prf_read_enable = sel_fire ? sel_e.src_valid : '0;
    assign prf_read_prn    = sel_fire ? sel_e.src_prn   : '0;

    // Entry storage: allocate, free on select, otherwise absorb wakeups.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_SIZE; i++)
                q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < QUEUE_SIZE; i++)
                q[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (alloc_oh[i])
                    q[i] <= enq_e;
                else if (free_oh[i])
                    q[i].valid <= 1'b0;
                else if (q[i].valid)
                    for (int s = 0; s < MAX_OPERANDS; s++)
                        if (q[i].src_valid[s] && prn_match(q[i].src_prn[s], wv_pad, wp_pad))
                            q[i].src_ready[s] <= 1'b1;
            end
        end
    end

    // Issue register: loads on select, holds under backpressure, drains on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid     <= 1'b0;
            issue_inst_id   <= '0;
            issue_raw_instr <= '0;
            issue_pc        <= '0;
            issue_operands  <= '0;
            issue_dst_valid <= '0;
            issue_dst_prn   <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (sel_fire) begin
            issue_valid     <= 1'b1;
            issue_inst_id   <= sel_e.inst_id;
            issue_raw_instr <= sel_e.raw_instr;
            issue_pc        <= sel_e.pc;
            issue_dst_valid <= sel_e.dst_valid;
            issue_dst_prn   <= sel_e.dst_prn;
            for (int s = 0; s < MAX_OPERANDS; s++)
                issue_operands[s] <= sel_e.src_valid[s] ? prf_op[s] : 64'd0;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

    // Occupancy: +1 per accepted enqueue, -1 per select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (flush)
            count <= '0;
        else
            count <= count + CNT_W'(enq_fire) - CNT_W'(sel_fire);
    end

endmodule

// File: tb/tb_fu_issue_queue.sv
// Directed bench for fu_issue_queue: one out-of-order and one in-order
// instance share the same stimulus.
module tb_fu_issue_queue;

    localparam int NO = 3;
    localparam int PW = 6;
    localparam int IW = 6;
    localparam int WP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic enq_valid = 1'b0;
    logic issue_ready = 1'b1;
    logic [IW-1:0]          enq_inst_id = '0;
    logic [31:0]            enq_raw_instr = '0;
    logic [63:0]            enq_pc = '0;
    logic [NO-1:0]          enq_src_valid = '0, enq_src_ready = '0, enq_dst_valid = '0;
    logic [NO-1:0][PW-1:0]  enq_src_prn = '0, enq_dst_prn = '0;
    logic [WP-1:0]          wake_valid = '0;
    logic [WP-1:0][PW-1:0]  wake_prn = '0;

    logic                   a_enq_ready, b_enq_ready, a_iv, b_iv;
    logic [NO-1:0]          a_pre, b_pre, a_idv, b_idv;
    logic [NO-1:0][PW-1:0]  a_prn, b_prn, a_idp, b_idp;
    logic [NO-1:0][63:0]    a_prf_op, b_prf_op, a_ops, b_ops;
    logic [IW-1:0]          a_id, b_id;
    logic [31:0]            a_raw, b_raw;
    logic [63:0]            a_pc, b_pc;
    logic [3:0]             a_occ, b_occ;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // PRF model: value encodes slot and PRN so captured operands are traceable.
    always_comb begin
        for (int s = 0; s < NO; s++) begin
            a_prf_op[s] = {16'hC0DE, 16'h0000, 16'(s), 10'h000, a_prn[s]};
            b_prf_op[s] = {16'hC0DE, 16'h0000, 16'(s), 10'h000, b_prn[s]};
        end
    end

    fu_issue_queue #(.IN_ORDER(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(a_enq_ready), .enq_inst_id(enq_inst_id),
        .enq_raw_instr(enq_raw_instr), .enq_pc(enq_pc),
        .enq_src_valid(enq_src_valid), .enq_src_ready(enq_src_ready), .enq_src_prn(enq_src_prn),
        .enq_dst_valid(enq_dst_valid), .enq_dst_prn(enq_dst_prn),
        .wake_valid(wake_valid), .wake_prn(wake_prn),
        .prf_read_enable(a_pre), .prf_read_prn(a_prn), .prf_op(a_prf_op),
        .issue_valid(a_iv), .issue_ready(issue_ready), .issue_inst_id(a_id),
        .issue_raw_instr(a_raw), .issue_pc(a_pc), .issue_operands(a_ops),
        .issue_dst_valid(a_idv), .issue_dst_prn(a_idp), .occupancy(a_occ)
    );

    fu_issue_queue #(.IN_ORDER(1)) u_dut_io (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(b_enq_ready), .enq_inst_id(enq_inst_id),
        .enq_raw_instr(enq_raw_instr), .enq_pc(enq_pc),
        .enq_src_valid(enq_src_valid), .enq_src_ready(enq_src_ready), .enq_src_prn(enq_src_prn),
        .enq_dst_valid(enq_dst_valid), .enq_dst_prn(enq_dst_prn),
        .wake_valid(wake_valid), .wake_prn(wake_prn),
        .prf_read_enable(b_pre), .prf_read_prn(b_prn), .prf_op(b_prf_op),
        .issue_valid(b_iv), .issue_ready(issue_ready), .issue_inst_id(b_id),
        .issue_raw_instr(b_raw), .issue_pc(b_pc), .issue_operands(b_ops),
        .issue_dst_valid(b_idv), .issue_dst_prn(b_idp), .occupancy(b_occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source PRNs are p0, p0+1, p0+2; dst slot 0 carries id^0x20; pc = 0x4000|id.
    task automatic set_enq(input logic [5:0] id, input logic [2:0] sv,
                           input logic [2:0] sr, input logic [5:0] p0);
        enq_valid      = 1'b1;
        enq_inst_id    = id;
        enq_raw_instr  = {26'h0, id};
        enq_pc         = {58'h0, id} | 64'h4000;
        enq_src_valid  = sv;
        enq_src_ready  = sr;
        enq_src_prn[0] = p0;
        enq_src_prn[1] = p0 + 6'd1;
        enq_src_prn[2] = p0 + 6'd2;
        enq_dst_valid  = 3'b001;
        enq_dst_prn    = '0;
        enq_dst_prn[0] = id ^ 6'h20;
    endtask

    task automatic clr_enq();
        enq_valid     = 1'b0;
        enq_inst_id   = '0;
        enq_src_valid = '0;
        enq_src_ready = '0;
        enq_src_prn   = '0;
        enq_dst_valid = '0;
        enq_dst_prn   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values while rst is held low
        #2;
        chk("rst_occ",  64'(a_occ), 64'd0);
        chk("rst_iv",   64'(a_iv), 64'd0);
        chk("rst_erdy", 64'(a_enq_ready), 64'd1);
        chk("rst_pre",  64'(a_pre), 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Latency: enqueue with all sources ready
        set_enq(6'd5, 3'b011, 3'b011, 6'd1);
        #1;
        chk("lat_erdy", 64'(a_enq_ready), 64'd1);
        tick();
        clr_enq();
        #1;
        chk("lat_occ1", 64'(a_occ), 64'd1);
        chk("lat_pre",  64'(a_pre), 64'h3);
        chk("lat_prn0", 64'(a_prn[0]), 64'd1);
        chk("lat_prn1", 64'(a_prn[1]), 64'd2);
        chk("lat_iv0",  64'(a_iv), 64'd0);
        tick();
        chk("lat_iv1",  64'(a_iv), 64'd1);
        chk("lat_id",   64'(a_id), 64'd5);
        chk("lat_op0",  a_ops[0], 64'hC0DE_0000_0000_0001);
        chk("lat_op1",  a_ops[1], 64'hC0DE_0000_0001_0002);
        chk("lat_op2",  a_ops[2], 64'd0);
        chk("lat_dst",  64'(a_idp[0]), 64'h25);
        chk("lat_pc",   a_pc, 64'h4005);
        chk("lat_occ0", 64'(a_occ), 64'd0);
        chk("lat_io_id", 64'(b_id), 64'd5);
        tick();
        chk("lat_drain", 64'(a_iv), 64'd0);

        // Out-of-order wake: A waits on PRN 7, B is ready
        set_enq(6'd10, 3'b001, 3'b000, 6'd7);
        tick();
        set_enq(6'd11, 3'b001, 3'b001, 6'd3);
        #1;
        chk("ooo_a_blocked", 64'(a_pre), 64'd0);
        tick();
        clr_enq();
        #1;
        chk("ooo_b_sel",     64'(a_pre), 64'h1);
        chk("ooo_b_prn",     64'(a_prn[0]), 64'd3);
        chk("io_b_waits",    64'(b_pre), 64'd0);
        tick();
        wake_valid[3] = 1'b1;
        wake_prn[3]   = 6'd7;
        #1;
        chk("ooo_b_iv",      64'(a_iv), 64'd1);
        chk("ooo_b_id",      64'(a_id), 64'd11);
        chk("ooo_no_bypass", 64'(a_pre), 64'd0);
        chk("io_iv0",        64'(b_iv), 64'd0);
        tick();
        wake_valid = '0;
        wake_prn   = '0;
        #1;
        chk("ooo_a_sel",     64'(a_pre), 64'h1);
        chk("ooo_a_prn",     64'(a_prn[0]), 64'd7);
        chk("io_a_sel",      64'(b_pre), 64'h1);
        chk("io_a_prn",      64'(b_prn[0]), 64'd7);
        chk("ooo_gap",       64'(a_iv), 64'd0);
        tick();
        chk("ooo_a_id",      64'(a_id), 64'd10);
        chk("ooo_a_iv",      64'(a_iv), 64'd1);
        chk("io_a_id",       64'(b_id), 64'd10);
        chk("io_b_sel_prn",  64'(b_prn[0]), 64'd3);
        chk("io_b_sel",      64'(b_pre), 64'h1);
        tick();
        chk("io_b_id",       64'(b_id), 64'd11);
        chk("io_b_iv",       64'(b_iv), 64'd1);
        chk("ooo_occ_end",   64'(a_occ), 64'd0);
        chk("ooo_iv_end",    64'(a_iv), 64'd0);
        tick();

        // Wake arriving in the enqueue cycle
        set_enq(6'd20, 3'b001, 3'b000, 6'd12);
        wake_valid[0] = 1'b1;
        wake_prn[0]   = 6'd12;
        tick();
        clr_enq();
        wake_valid = '0;
        wake_prn   = '0;
        #1;
        chk("ew_sel", 64'(a_pre), 64'h1);
        chk("ew_prn", 64'(a_prn[0]), 64'd12);
        tick();
        chk("ew_iv",  64'(a_iv), 64'd1);
        chk("ew_id",  64'(a_id), 64'd20);
        chk("ew_op0", a_ops[0], 64'hC0DE_0000_0000_000C);
        tick();

        // Full queue under backpressure
        issue_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_enq(6'(k), 3'b000, 3'b000, 6'd0);
            #1;
            chk("fill_erdy", 64'(a_enq_ready), 64'd1);
            tick();
        end
        set_enq(6'd9, 3'b000, 3'b000, 6'd0);
        #1;
        for (int r = 0; r < 5; r++) begin
            chk("full_erdy", 64'(a_enq_ready), 64'd0);
            chk("full_iv",   64'(a_iv), 64'd1);
            chk("full_id",   64'(a_id), 64'd0);
            chk("full_occ",  64'(a_occ), 64'd8);
            tick();
        end
        issue_ready = 1'b1;
        #1;
        chk("full_same_cycle", 64'(a_enq_ready), 64'd0);
        tick();
        chk("drain_erdy", 64'(a_enq_ready), 64'd1);
        chk("drain_id1",  64'(a_id), 64'd1);
        chk("drain_occ7", 64'(a_occ), 64'd7);
        chk("drain_ops",  a_ops[0], 64'd0);
        clr_enq();
        tick();
        chk("drain_id2",  64'(a_id), 64'd2);
        chk("drain_occ6", 64'(a_occ), 64'd6);
        for (int w = 0; w < 20; w++) begin
            if (a_occ == 4'd0 && !a_iv) break;
            tick();
        end
        chk("drain_done_occ", 64'(a_occ), 64'd0);
        chk("drain_done_iv",  64'(a_iv), 64'd0);

        // Flush with occupancy 5 and a same-cycle enqueue
        issue_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_enq(6'(40 + k), 3'b001, 3'b001, 6'(40 + k));
            tick();
        end
        set_enq(6'd50, 3'b001, 3'b001, 6'd50);
        flush = 1'b1;
        issue_ready = 1'b1;
        #1;
        chk("fl_pre_occ",  64'(a_occ), 64'd5);
        chk("fl_pre_iv",   64'(a_iv), 64'd1);
        chk("fl_no_read",  64'(a_pre), 64'd0);
        tick();
        flush = 1'b0;
        clr_enq();
        #1;
        chk("fl_occ",    64'(a_occ), 64'd0);
        chk("fl_iv",     64'(a_iv), 64'd0);
        chk("fl_erdy",   64'(a_enq_ready), 64'd1);
        chk("fl_io_occ", 64'(b_occ), 64'd0);
        chk("fl_empty",  64'(a_pre), 64'd0);
        tick();
        chk("fl_occ2",   64'(a_occ), 64'd0);
        chk("fl_iv2",    64'(a_iv), 64'd0);

        // Asynchronous reset in the middle of a cycle
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_enq(6'(60 + k), 3'b000, 3'b000, 6'd0);
            tick();
        end
        clr_enq();
        #1;
        chk("mr_occ3", 64'(a_occ), 64'd3);
        chk("mr_iv1",  64'(a_iv), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_occ",  64'(a_occ), 64'd0);
        chk("ar_iv",   64'(a_iv), 64'd0);
        chk("ar_erdy", 64'(a_enq_ready), 64'd1);
        tick();
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
